// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 status codes, icodes, register IDs and write-back FSM states
package y86_pkg;
  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  typedef enum logic {ST_RUN, ST_STOPPED} wb_state_t;
  function automatic logic stop_code(input logic [2:0] s);
    return s == SHLT || s == SADR || s == SINS;
  endfunction
endpackage

// File: rtl/stage_reg.sv
// stage_reg: enabled pipeline register with synchronous bubble load (ports: clk, rst, en, bubble, d, q)
module stage_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] BUB = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= (rst || (en && bubble)) ? BUB : en ? d : q;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: Y86-64 M->W pipeline register, regfile write masking, status and RUN/STOPPED FSM; inputs Clk/Reset/W_stall/W_bubble/M fields, outputs W fields, rf_dst*, Stat, halted, retire_cnt (counter only with WB_RETIRE_CNT_EN)
module writeback_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              W_stall,
  input  logic              W_bubble,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        M_icode,
  input  logic [REG_W-1:0]  M_dstE,
  input  logic [REG_W-1:0]  M_dstM,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  output logic [3:0]        W_icode,
  output logic [2:0]        W_stat,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [REG_W-1:0]  W_dstE,
  output logic [REG_W-1:0]  W_dstM,
  output logic [REG_W-1:0]  rf_dstE,
  output logic [REG_W-1:0]  rf_dstM,
  output logic [2:0]        Stat,
  output logic              halted,
  output logic [63:0]       retire_cnt
);
  localparam logic [REG_W-1:0] R_NONE = {REG_W{1'b1}};
  wb_state_t state, state_nx;
  logic en, run_ok;
  // a stopping code sitting in W freezes the register so Stat keeps it while the FSM stops
  assign en = state == ST_RUN && !stop_code(W_stat) && !W_stall;
  stage_reg #(.W(3), .BUB(SBUB)) u_stat (.clk(Clk), .rst(Reset), .en(en), .bubble(W_bubble), .d(m_stat), .q(W_stat));
  stage_reg #(.W(4), .BUB(INOP)) u_icode (.clk(Clk), .rst(Reset), .en(en), .bubble(W_bubble), .d(M_icode), .q(W_icode));
  stage_reg #(.W(REG_W), .BUB(R_NONE)) u_dst_e (.clk(Clk), .rst(Reset), .en(en), .bubble(W_bubble), .d(M_dstE), .q(W_dstE));
  stage_reg #(.W(REG_W), .BUB(R_NONE)) u_dst_m (.clk(Clk), .rst(Reset), .en(en), .bubble(W_bubble), .d(M_dstM), .q(W_dstM));
  stage_reg #(.W(DATA_W), .BUB('0)) u_val_e (.clk(Clk), .rst(Reset), .en(en), .bubble(W_bubble), .d(M_valE), .q(W_valE));
  stage_reg #(.W(DATA_W), .BUB('0)) u_val_m (.clk(Clk), .rst(Reset), .en(en), .bubble(W_bubble), .d(m_valM), .q(W_valM));
  always_ff @(posedge Clk)
    state <= Reset ? ST_RUN : state_nx;
  always_comb
    state_nx = (state == ST_RUN && stop_code(W_stat)) ? ST_STOPPED : state;
  always_comb begin
    halted  = state == ST_STOPPED;
    run_ok  = state == ST_RUN && W_stat == SAOK;
    rf_dstE = run_ok ? W_dstE : R_NONE;
    rf_dstM = run_ok ? W_dstM : R_NONE;
    Stat    = W_stat == SBUB ? SAOK : W_stat;
  end
`ifdef WB_RETIRE_CNT_EN
  logic w_fresh;
  logic [63:0] cnt_q;
  always_ff @(posedge Clk)
    w_fresh <= !Reset && en && !W_bubble;
  always_ff @(posedge Clk)
    cnt_q <= Reset ? 64'd0 : (run_ok && w_fresh) ? cnt_q + 64'd1 : cnt_q;
  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = 64'd0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed and randomized self-checking bench for writeback_stage
module tb_writeback_stage;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0, W_stall = 1'b0, W_bubble = 1'b0;
  logic [2:0]  m_stat = 3'd0;
  logic [3:0]  M_icode = 4'h1, M_dstE = 4'hF, M_dstM = 4'hF;
  logic [63:0] M_valE = 64'd0, m_valM = 64'd0;
  logic [3:0]  W_icode, W_dstE, W_dstM, rf_dstE, rf_dstM;
  logic [2:0]  W_stat, Stat;
  logic [63:0] W_valE, W_valM, retire_cnt;
  logic        halted;
  int checks = 0, failures = 0;
  logic [2:0]  x_stat;
  logic [3:0]  x_icode, x_dstE, x_dstM;
  logic [63:0] x_valE, x_valM, x_cnt;
  logic        x_stop, x_fresh;

  writeback_stage dut (
    .Clk(Clk), .Reset(Reset), .W_stall(W_stall), .W_bubble(W_bubble), .m_stat(m_stat),
    .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_icode(W_icode), .W_stat(W_stat), .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE),
    .W_dstM(W_dstM), .rf_dstE(rf_dstE), .rf_dstM(rf_dstM), .Stat(Stat), .halted(halted),
    .retire_cnt(retire_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic ok;
    ok = !x_stop && x_stat == 3'd1;
    chk({tag, ".W_stat"}, 64'(W_stat), 64'(x_stat));
    chk({tag, ".W_icode"}, 64'(W_icode), 64'(x_icode));
    chk({tag, ".W_dstE"}, 64'(W_dstE), 64'(x_dstE));
    chk({tag, ".W_dstM"}, 64'(W_dstM), 64'(x_dstM));
    chk({tag, ".W_valE"}, W_valE, x_valE);
    chk({tag, ".W_valM"}, W_valM, x_valM);
    chk({tag, ".rf_dstE"}, 64'(rf_dstE), ok ? 64'(x_dstE) : 64'hF);
    chk({tag, ".rf_dstM"}, 64'(rf_dstM), ok ? 64'(x_dstM) : 64'hF);
    chk({tag, ".Stat"}, 64'(Stat), x_stat == 3'd0 ? 64'd1 : 64'(x_stat));
    chk({tag, ".halted"}, 64'(halted), 64'(x_stop));
    chk({tag, ".retire_cnt"}, retire_cnt, x_cnt);
  endtask

  // Reference: the W register is a snapshot of the last accepted M instruction; a status of
  // halt/address/instruction error freezes it and stops the machine one edge later.
  task automatic model_edge(input logic r, s, b);
    logic stopping;
    if (r) begin
      {x_stat, x_icode, x_dstE, x_dstM, x_valE, x_valM} = {3'd0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0};
      x_stop = 1'b0; x_fresh = 1'b0; x_cnt = 64'd0;
    end else begin
      stopping = x_stat inside {3'd2, 3'd3, 3'd4};
`ifdef WB_RETIRE_CNT_EN
      if (!x_stop && x_fresh && x_stat == 3'd1) x_cnt = x_cnt + 64'd1;
`endif
      if (x_stop || stopping || s) x_fresh = 1'b0;
      else if (b) begin
        {x_stat, x_icode, x_dstE, x_dstM, x_valE, x_valM} = {3'd0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0};
        x_fresh = 1'b0;
      end else begin
        {x_stat, x_icode, x_dstE, x_dstM, x_valE, x_valM} = {m_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM};
        x_fresh = 1'b1;
      end
      if (stopping) x_stop = 1'b1;
    end
  endtask

  task automatic step(input string tag, input logic r, s, b, input logic [2:0] st,
                      input logic [3:0] de, dm, input logic [63:0] ve);
    Reset = r; W_stall = s; W_bubble = b; m_stat = st;
    M_icode = 4'($urandom_range(0, 11)); M_dstE = de; M_dstM = dm;
    M_valE = ve; m_valM = {$urandom, $urandom};
    @(posedge Clk);
    model_edge(r, s, b);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] st;
    x_stop = 1'b0; x_fresh = 1'b0; x_cnt = 64'd0;
    step("reset0", 1, $urandom, $urandom, 3'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom});
    step("reset1", 1, $urandom, $urandom, 3'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom});
    step("load", 0, 0, 0, 3'd1, 4'h0, 4'hF, 64'h5);
    step("retire", 0, 0, 0, 3'd1, 4'h2, 4'h7, 64'h22);
    step("stall", 0, 1, 0, 3'd1, 4'h9, 4'h9, 64'h99);
    step("stall2", 0, 1, 0, 3'd1, 4'h8, 4'h8, 64'h88);
    step("stall_bub", 0, 1, 1, 3'd1, 4'h6, 4'h6, 64'h66);
    step("bubble", 0, 0, 1, 3'd1, 4'h5, 4'h5, 64'h55);
    step("same_dst", 0, 0, 0, 3'd1, 4'h4, 4'h4, 64'h44);
    step("exc_load", 0, 0, 0, 3'd3, 4'h1, 4'h3, 64'h33);
    step("exc_stop", 0, 0, 0, 3'd1, 4'h2, 4'h2, 64'h12);
    step("exc_hold", 0, 0, 0, 3'd1, 4'h6, 4'h6, 64'h16);
    step("exc_bub", 0, 0, 1, 3'd1, 4'h6, 4'h6, 64'h16);
    step("rst_a", 1, 0, 0, 3'd1, 4'h0, 4'h0, 64'h0);
    step("hlt_pre", 0, 0, 0, 3'd1, 4'h1, 4'hF, 64'h7);
    step("hlt_load", 0, 0, 0, 3'd2, 4'hF, 4'hF, 64'h0);
    step("hlt_stop", 0, 0, 0, 3'd1, 4'h3, 4'h3, 64'h3);
    step("hlt_hold", 0, 1, 1, 3'd1, 4'h3, 4'h3, 64'h3);
    step("hlt_rst", 1, 0, 0, 3'd1, 4'h3, 4'h3, 64'h3);
    step("post_rst", 0, 0, 0, 3'd1, 4'hA, 4'hB, 64'hAB);
`ifdef WB_RETIRE_CNT_EN
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cnt_q;
    x_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    step("wrap", 0, 1, 0, 3'd1, 4'h1, 4'h1, 64'h1);
`endif
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 19))
        0, 1:    st = 3'd0;
        2:       st = 3'($urandom_range(2, 4));
        default: st = 3'd1;
      endcase
      step("rand", (x_stop && $urandom_range(0, 2) == 0) || $urandom_range(0, 99) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, st,
           4'($urandom), 4'($urandom), {$urandom, $urandom});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
